// File: rtl/sram_stub_pkg.sv
// sram_stub_pkg: shared state type, latency limit and address-width helper for the SRAM stub
package sram_stub_pkg;
  typedef enum logic {CLEAR, READY} sram_state_t;
  localparam int MAX_READ_LATENCY = 4;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sram_read_pipe.sv
// sram_read_pipe: valid+data delay line whose last stage holds its data until the next valid
module sram_read_pipe #(
  parameter int WIDTH = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0][WIDTH-1:0] d;
  // a stage only loads when the data arriving at it is valid, so every stage holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
    end else begin
      v <= LATENCY'({v, in_valid});
      for (int i = LATENCY - 1; i > 0; i--) if (v[i-1]) d[i] <= d[i-1];
      if (in_valid) d[0] <= in_data;
    end
  end
  assign out_valid = v[LATENCY-1];
  assign out_data = d[LATENCY-1];
endmodule

// File: rtl/sram_stub_param.sv
// sram_stub_param: single-port SRAM model with lane write mask, pipelined reads and self-clearing sweep
module sram_stub_param
  import sram_stub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH = 512,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  output logic                                  ready,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic                                  cen,
  input  logic                                  wen,
  input  logic [FETCH_WIDTH-1:0]                wmask,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] data_in,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                  data_out_valid
);
  typedef logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] word_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("sram_stub_param: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
  end
  word_t mem [DEPTH];
  word_t rd, merged;
  sram_state_t state;
  logic [ADDR_W-1:0] ptr;
  logic acc, in_range;
  assign acc = ready & cen;
  assign in_range = 32'(addr) < DEPTH;
  // out-of-range addresses read as zero and never reach the array
  always_comb begin
    rd = in_range ? mem[addr] : '0;
    merged = rd;
    for (int i = 0; i < FETCH_WIDTH; i++) merged[i] = wmask[i] ? data_in[i] : rd[i];
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (acc && wen && in_range) mem[addr] <= merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ready <= 1'b0;
      ptr <= '0;
    end else if (state == CLEAR) begin
      state <= ptr == LAST ? READY : CLEAR;
      ready <= ptr == LAST;
      ptr <= ptr == LAST ? '0 : ptr + ADDR_W'(1);
    end else if (clr) begin
      state <= CLEAR;
      ready <= 1'b0;
      ptr <= '0;
    end
  end
  sram_read_pipe #(
    .WIDTH(FETCH_WIDTH * DATA_WIDTH),
    .LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(acc & ~wen),
    .in_data(rd),
    .out_valid(data_out_valid),
    .out_data(data_out)
  );
endmodule

// File: tb/tb_sram_stub_param.sv
// tb_sram_stub_param: directed tests on an 8-deep latency-3 instance and a 6-deep latency-2 instance
module tb_sram_stub_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_clr = 0, a_cen = 0, a_wen = 0;
  logic [2:0] a_addr = '0;
  logic [3:0] a_wmask = '0;
  logic [3:0][15:0] a_din = '0;
  logic [3:0][15:0] a_dout;
  logic a_ready, a_valid;
  logic b_clr = 0, b_cen = 0, b_wen = 0;
  logic [2:0] b_addr = '0;
  logic [3:0] b_wmask = '0;
  logic [3:0][15:0] b_din = '0;
  logic [3:0][15:0] b_dout;
  logic b_ready, b_valid;
  int checks = 0;
  int errors = 0;
  localparam logic [63:0] V1 = 64'h0001_0011_0111_1111;
  localparam logic [63:0] V2 = 64'h2222_0220_0022_0002;
  localparam logic [63:0] V3 = 64'h3333_3003_0303_0033;
  localparam logic [63:0] P = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] Q = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] X = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] Y = 64'h0F0F_F0F0_5A5A_A5A5;

  always #5 clk = ~clk;

  sram_stub_param #(.DATA_WIDTH(16), .FETCH_WIDTH(4), .DEPTH(8), .READ_LATENCY(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .ready(a_ready), .addr(a_addr), .cen(a_cen),
    .wen(a_wen), .wmask(a_wmask), .data_in(a_din), .data_out(a_dout), .data_out_valid(a_valid)
  );
  sram_stub_param #(.DATA_WIDTH(16), .FETCH_WIDTH(4), .DEPTH(6), .READ_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .ready(b_ready), .addr(b_addr), .cen(b_cen),
    .wen(b_wen), .wmask(b_wmask), .data_in(b_din), .data_out(b_dout), .data_out_valid(b_valid)
  );

  task automatic a_drive(input logic c, input logic ce, input logic we, input logic [2:0] ad,
                         input logic [3:0] m, input logic [63:0] d);
    a_clr = c; a_cen = ce; a_wen = we; a_addr = ad; a_wmask = m; a_din = d;
    @(negedge clk);
  endtask

  task automatic b_drive(input logic ce, input logic we, input logic [2:0] ad,
                         input logic [3:0] m, input logic [63:0] d);
    b_cen = ce; b_wen = we; b_addr = ad; b_wmask = m; b_din = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || a_valid !== 1'b0 || a_dout !== '0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b dout=%h b_ready=%b, expected 0 0 0 0",
               a_ready, a_valid, a_dout, b_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (a_ready !== 1'(k == 8)) begin
        errors++;
        $display("FAIL reset_ready_cycle%0d: ready=%b expected %b", k, a_ready, k == 8);
      end
    end
    for (int a = 0; a < 8; a++) begin
      a_drive(0, 1, 0, 3'(a), 0, 0);
      a_drive(0, 0, 0, 0, 0, 0);
      a_drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (a_valid !== 1'b1 || a_dout !== '0) begin
        errors++;
        $display("FAIL reset_zero_addr%0d: valid=%b dout=%h expected 1 0", a, a_valid, a_dout);
      end
    end
  endtask

  task automatic test_mask;
    a_drive(0, 1, 1, 5, 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1});
    a_drive(0, 1, 1, 5, 4'b0101, {4{16'd9}});
    a_drive(0, 1, 1, 5, 4'b0000, {4{16'hFFFF}});
    a_drive(0, 1, 0, 5, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== {16'd4, 16'd9, 16'd2, 16'd9}) begin
      errors++;
      $display("FAIL mask_merge: valid=%b dout=%h expected 1 0004000900020009", a_valid, a_dout);
    end
  endtask

  task automatic test_pipeline;
    a_drive(0, 1, 1, 1, 4'hF, V1);
    a_drive(0, 1, 1, 2, 4'hF, V2);
    a_drive(0, 1, 1, 3, 4'hF, V3);
    a_drive(0, 1, 0, 1, 0, 0);
    a_drive(0, 1, 0, 2, 0, 0);
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL pipe_early: valid=%b expected 0", a_valid);
    end
    a_drive(0, 1, 0, 3, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== V1) begin
      errors++;
      $display("FAIL pipe_rd1: valid=%b dout=%h expected 1 %h", a_valid, a_dout, V1);
    end
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== V2) begin
      errors++;
      $display("FAIL pipe_rd2: valid=%b dout=%h expected 1 %h", a_valid, a_dout, V2);
    end
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== V3) begin
      errors++;
      $display("FAIL pipe_rd3: valid=%b dout=%h expected 1 %h", a_valid, a_dout, V3);
    end
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b0 || a_dout !== V3) begin
      errors++;
      $display("FAIL pipe_hold: valid=%b dout=%h expected 0 %h", a_valid, a_dout, V3);
    end
  endtask

  task automatic test_war;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL war_ready: ready=%b expected 1", b_ready);
    end
    b_drive(1, 1, 5, 4'hF, P);
    b_drive(1, 0, 5, 0, 0);
    b_drive(1, 1, 5, 4'hF, Q);
    checks++;
    if (b_valid !== 1'b1 || b_dout !== P) begin
      errors++;
      $display("FAIL war_old: valid=%b dout=%h expected 1 %h", b_valid, b_dout, P);
    end
    b_drive(1, 0, 5, 0, 0);
    b_drive(0, 0, 0, 0, 0);
    checks++;
    if (b_valid !== 1'b1 || b_dout !== Q) begin
      errors++;
      $display("FAIL war_new: valid=%b dout=%h expected 1 %h", b_valid, b_dout, Q);
    end
    b_drive(1, 1, 6, 4'hF, {4{16'hFFFF}});
    b_drive(1, 0, 6, 0, 0);
    b_drive(1, 0, 7, 0, 0);
    checks++;
    if (b_valid !== 1'b1 || b_dout !== '0) begin
      errors++;
      $display("FAIL oor_addr6: valid=%b dout=%h expected 1 0", b_valid, b_dout);
    end
    b_drive(0, 0, 0, 0, 0);
    checks++;
    if (b_valid !== 1'b1 || b_dout !== '0) begin
      errors++;
      $display("FAIL oor_addr7: valid=%b dout=%h expected 1 0", b_valid, b_dout);
    end
  endtask

  task automatic test_clear;
    int cnt = 0;
    int nv = 0;
    a_drive(0, 1, 1, 4, 4'hF, X);
    a_drive(0, 1, 0, 4, 0, 0);
    a_drive(1, 1, 0, 4, 0, 0);
    while (a_ready !== 1'b1 && cnt < 20) begin
      if (a_valid === 1'b1) begin
        nv++;
        checks++;
        if (a_dout !== X) begin
          errors++;
          $display("FAIL clr_inflight_data: dout=%h expected %h", a_dout, X);
        end
      end
      cnt++;
      a_drive(0, 1, 1, 3, 4'hF, {4{16'hFFFF}});
    end
    checks++;
    if (cnt != 8 || nv != 2) begin
      errors++;
      $display("FAIL clr_sweep: low_cycles=%0d strobes=%0d expected 8 2", cnt, nv);
    end
    for (int a = 0; a < 8; a++) begin
      a_drive(0, 1, 0, 3'(a), 0, 0);
      a_drive(0, 0, 0, 0, 0, 0);
      a_drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (a_valid !== 1'b1 || a_dout !== '0) begin
        errors++;
        $display("FAIL clr_zero_addr%0d: valid=%b dout=%h expected 1 0", a, a_valid, a_dout);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    int nv = 0;
    a_drive(0, 1, 1, 2, 4'hF, Y);
    a_drive(0, 1, 0, 2, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== Y) begin
      errors++;
      $display("FAIL rstmid_preread: valid=%b dout=%h expected 1 %h", a_valid, a_dout, Y);
    end
    a_drive(0, 1, 0, 2, 0, 0);
    a_drive(1, 0, 0, 0, 0, 0);
    a_clr = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_dout !== '0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b dout=%h ready=%b expected 0 0 0", a_valid, a_dout, a_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    while (a_ready !== 1'b1 && cnt < 20) begin
      if (a_valid === 1'b1) nv++;
      cnt++;
      a_drive(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (cnt != 8 || nv != 0) begin
      errors++;
      $display("FAIL rstmid_sweep: low_cycles=%0d strobes=%0d expected 8 0", cnt, nv);
    end
    a_drive(0, 1, 0, 2, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    a_drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_dout !== '0) begin
      errors++;
      $display("FAIL rstmid_zero: valid=%b dout=%h expected 1 0", a_valid, a_dout);
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_pipeline();
    test_war();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
